// File: rtl/logcap_pkg.sv
// logcap_pkg: shared definitions for the logic-capture command sequencer.
// Holds the capture-core function codes, status bit positions, the sequencer
// state enumeration, the request payload struct and a command legality helper.
package logcap_pkg;

   localparam int unsigned CMD_W    = 8;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned STATUS_W = 8;

   // Capture-core function codes
   localparam logic [CMD_W-1:0] CMD_NOP                 = 8'h00;
   localparam logic [CMD_W-1:0] CMD_START               = 8'h01;
   localparam logic [CMD_W-1:0] CMD_ABORT               = 8'h02;
   localparam logic [CMD_W-1:0] CMD_TRIGGER_CONFIGURE   = 8'h03;
   localparam logic [CMD_W-1:0] CMD_BUFFER_CONFIGURE    = 8'h04;
   localparam logic [CMD_W-1:0] CMD_READ_TRACE_DATA     = 8'h05;
   localparam logic [CMD_W-1:0] CMD_READ_TRACE_SIZE     = 8'h06;
   localparam logic [CMD_W-1:0] CMD_READ_TRIGGER_SAMPLE = 8'h07;
   localparam logic [CMD_W-1:0] CMD_ACK                 = 8'h08;
   localparam logic [CMD_W-1:0] CMD_RESET               = 8'h09;

   // Status bit positions
   localparam int unsigned IDLE_BIT = 0;
   localparam int unsigned ACK_BIT  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_CAPTURE,
      ST_SEND_ACK,
      ST_WAIT_RELEASE,
      ST_RESPOND
   } seq_state_t;

   // Command plus register payload offered by one requester
   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] data;
   } req_t;

   // NOP and ACK are reserved for the handshake and never issued on request
   function automatic logic is_illegal_cmd(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_NOP) || (cmd == CMD_ACK);
   endfunction

endpackage

// File: rtl/logcap_rr_arbiter.sv
// logcap_rr_arbiter: two-requester round-robin arbiter.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   req[1:0]     - pending requests
//   take         - the current grant is consumed this cycle
//   gnt_valid_c  - some request is pending (combinational)
//   gnt_id_c     - requester that would be granted (combinational)
// The last-grant register resets to 1 so requester 0 wins the first tie.
module logcap_rr_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       take,
   output logic       gnt_valid_c,
   output logic       gnt_id_c
);

   logic last_gnt;

   // Tie goes to the requester that was not granted last
   always_comb begin
      gnt_valid_c = |req;
      gnt_id_c    = 1'b0;
      if (req == 2'b11) begin
         gnt_id_c = ~last_gnt;
      end else if (req[1]) begin
         gnt_id_c = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt <= 1'b1;
      end else if (take && gnt_valid_c) begin
         last_gnt <= gnt_id_c;
      end
   end

endmodule

// File: rtl/logcap_cmd_sequencer.sv
// logcap_cmd_sequencer: arbitrates two command requesters and runs the
// strobe / ack / capture / release handshake with the logic-capture core.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   req{0,1}Valid/Cmd/Data    - requester command, payload {regIn7..regIn0}
//   req{0,1}Ready             - one-cycle accept pulse
//   rspValid/rspId/rspData/rspError - one-cycle response with captured regOut
//   command, commandStrobe    - function code to the core, qualified by strobe
//   regIn                     - payload of the last granted request
//   regOut                    - core result registers
//   status                    - core status (ACK_BIT used, IDLE_BIT ignored)
// Optional feature: define LOGCAP_SEQ_TIMEOUT_EN to abort transactions that
// spend ACK_TIMEOUT_CLKS cycles in WAIT_ACK or WAIT_RELEASE.
module logcap_cmd_sequencer
   import logcap_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT_CLKS = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0Valid,
   input  logic              req1Valid,
   input  logic [CMD_W-1:0]  req0Cmd,
   input  logic [CMD_W-1:0]  req1Cmd,
   input  logic [DATA_W-1:0] req0Data,
   input  logic [DATA_W-1:0] req1Data,
   output logic              req0Ready,
   output logic              req1Ready,
   output logic              rspValid,
   output logic              rspId,
   output logic [DATA_W-1:0] rspData,
   output logic              rspError,
   output logic [CMD_W-1:0]  command,
   output logic              commandStrobe,
   output logic [DATA_W-1:0] regIn,
   input  logic [DATA_W-1:0] regOut,
   input  logic [STATUS_W-1:0] status
);

   seq_state_t state, state_next;

   logic gnt_valid_c;
   logic gnt_id_c;
   req_t req0_c, req1_c, gnt_req_c;
   logic ack_c;
   logic tmo_expired_c;

   logic              strobe_d;
   logic [CMD_W-1:0]  command_d;
   logic [1:0]        ready_d;
   logic              rsp_valid_d;
   logic              rsp_error_d;
   logic              rsp_id_d;
   logic [DATA_W-1:0] rsp_data_d;
   logic [DATA_W-1:0] reg_in_d;

   // Only the ack bit drives the handshake
   logic unused_status;
   assign unused_status = ^{status[STATUS_W-1:ACK_BIT+1], status[ACK_BIT-1:IDLE_BIT]};
   assign ack_c = status[ACK_BIT];

   assign req0_c    = '{cmd: req0Cmd, data: req0Data};
   assign req1_c    = '{cmd: req1Cmd, data: req1Data};
   assign gnt_req_c = gnt_id_c ? req1_c : req0_c;

   logcap_rr_arbiter u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         ({req1Valid, req0Valid}),
      .take        (state == ST_IDLE),
      .gnt_valid_c (gnt_valid_c),
      .gnt_id_c    (gnt_id_c)
   );

`ifdef LOGCAP_SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT_CLKS) + 1;
   logic [TMO_W-1:0] tmo_cnt;

   // Restarts on every state change, so it counts cycles within the current wait state
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (state_next != state) begin
         tmo_cnt <= '0;
      end else if ((state == ST_WAIT_ACK) || (state == ST_WAIT_RELEASE)) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign tmo_expired_c = (tmo_cnt == TMO_W'(ACK_TIMEOUT_CLKS - 1));
`else
   localparam int unsigned unused_timeout_clks = ACK_TIMEOUT_CLKS;
   assign tmo_expired_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; ack wins over a same-cycle timeout
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (gnt_valid_c) begin
               state_next = is_illegal_cmd(gnt_req_c.cmd) ? ST_RESPOND : ST_ISSUE;
            end
         end
         ST_ISSUE:     state_next = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (ack_c) begin
               state_next = ST_CAPTURE;
            end else if (tmo_expired_c) begin
               state_next = ST_RESPOND;
            end
         end
         ST_CAPTURE:   state_next = ST_SEND_ACK;
         ST_SEND_ACK:  state_next = ST_WAIT_RELEASE;
         ST_WAIT_RELEASE: begin
            if (!ack_c || tmo_expired_c) begin
               state_next = ST_RESPOND;
            end
         end
         ST_RESPOND:   state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs, keyed on the coming state
   always_comb begin
      strobe_d    = 1'b0;
      command_d   = CMD_NOP;
      ready_d     = '0;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_id_d    = rspId;
      rsp_data_d  = rspData;
      reg_in_d    = regIn;

      if ((state == ST_IDLE) && gnt_valid_c) begin
         ready_d[gnt_id_c] = 1'b1;
         reg_in_d          = gnt_req_c.data;
         rsp_id_d          = gnt_id_c;
         rsp_data_d        = '0;
      end

      if (state == ST_CAPTURE) begin
         rsp_data_d = regOut;
      end

      if (state_next == ST_ISSUE) begin
         strobe_d  = 1'b1;
         command_d = gnt_req_c.cmd;
      end

      if (state_next == ST_SEND_ACK) begin
         strobe_d  = 1'b1;
         command_d = CMD_ACK;
      end

      // Only a normal release reaches RESPOND error-free; illegal and timeout paths flag it
      if (state_next == ST_RESPOND) begin
         rsp_valid_d = 1'b1;
         rsp_error_d = !((state == ST_WAIT_RELEASE) && !ack_c);
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         commandStrobe <= 1'b0;
         command       <= CMD_NOP;
         req0Ready     <= 1'b0;
         req1Ready     <= 1'b0;
         rspValid      <= 1'b0;
         rspError      <= 1'b0;
         rspId         <= 1'b0;
         rspData       <= '0;
         regIn         <= '0;
      end else begin
         commandStrobe <= strobe_d;
         command       <= command_d;
         req0Ready     <= ready_d[0];
         req1Ready     <= ready_d[1];
         rspValid      <= rsp_valid_d;
         rspError      <= rsp_error_d;
         rspId         <= rsp_id_d;
         rspData       <= rsp_data_d;
         regIn         <= reg_in_d;
      end
   end

endmodule

// File: tb/tb_logcap_cmd_sequencer.sv
// tb_logcap_cmd_sequencer: self-checking bench for logcap_cmd_sequencer.
// A behavioural capture-core model answers strobes on status[3]/regOut;
// expected strobes and responses are queued when stimulus is driven and
// checked by a monitor as the DUT produces them.
module tb_logcap_cmd_sequencer;
   import logcap_pkg::*;

`ifdef LOGCAP_SEQ_TIMEOUT_EN
   localparam int unsigned TB_TMO = 16;
`else
   localparam int unsigned TB_TMO = 1024;
`endif

   typedef struct packed {
      logic        id;
      logic        err;
      logic [63:0] data;
   } exp_rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0Valid = 1'b0, req1Valid = 1'b0;
   logic [7:0]  req0Cmd = '0, req1Cmd = '0;
   logic [63:0] req0Data = '0, req1Data = '0;
   logic        req0Ready, req1Ready;
   logic        rspValid, rspId, rspError;
   logic [63:0] rspData;
   logic [7:0]  command;
   logic        commandStrobe;
   logic [63:0] regIn;
   logic [63:0] regOut = '0;
   logic [7:0]  status = '0;

   int checks = 0;
   int fails  = 0;
   int strobe_cnt = 0;
   logic tb_last = 1'b1;

   // Capture-core model controls
   int          ack_rise_dly = 1;
   int          ack_fall_dly = 1;
   logic        ack_never = 1'b0;
   logic        ack_hold = 1'b0;
   logic [63:0] cap_value = '0;
   int          rise_cnt = -1;
   int          fall_cnt = -1;

   logic [7:0] exp_cmd[$];
   exp_rsp_t   exp_rsp[$];

   logcap_cmd_sequencer #(.ACK_TIMEOUT_CLKS(TB_TMO)) dut (
      .clk(clk), .reset(reset),
      .req0Valid(req0Valid), .req1Valid(req1Valid),
      .req0Cmd(req0Cmd), .req1Cmd(req1Cmd),
      .req0Data(req0Data), .req1Data(req1Data),
      .req0Ready(req0Ready), .req1Ready(req1Ready),
      .rspValid(rspValid), .rspId(rspId), .rspData(rspData), .rspError(rspError),
      .command(command), .commandStrobe(commandStrobe),
      .regIn(regIn), .regOut(regOut), .status(status)
   );

   always #5 clk = ~clk;

   // Capture-core model: raises ack some cycles after a function strobe,
   // drops it some cycles after the CMD_ACK strobe
   always @(negedge clk) begin
      if (reset) begin
         status   = '0;
         rise_cnt = -1;
         fall_cnt = -1;
      end else begin
         if (commandStrobe && (command != CMD_ACK) && !ack_never) rise_cnt = ack_rise_dly;
         if (commandStrobe && (command == CMD_ACK) && !ack_hold)  fall_cnt = ack_fall_dly;
         if (rise_cnt == 0) begin
            status[ACK_BIT] = 1'b1;
            regOut          = cap_value;
         end
         if (rise_cnt >= 0) rise_cnt--;
         if (fall_cnt == 0) status[ACK_BIT] = 1'b0;
         if (fall_cnt >= 0) fall_cnt--;
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [7:0] ec;
      exp_rsp_t   er;
      if (!reset) begin
         checks++;
         if (commandStrobe) begin
            strobe_cnt++;
            if (exp_cmd.size() == 0) begin
               fails++;
               $display("FAIL unexpected_strobe: command=%02h, required no strobe", command);
            end else begin
               ec = exp_cmd.pop_front();
               if (command !== ec) begin
                  fails++;
                  $display("FAIL strobe_command: got %02h, expected %02h", command, ec);
               end
            end
         end else if (command !== CMD_NOP) begin
            fails++;
            $display("FAIL idle_command: got %02h, expected 00", command);
         end
         if (rspValid) begin
            checks++;
            if (exp_rsp.size() == 0) begin
               fails++;
               $display("FAIL unexpected_rsp: id=%0d err=%0d data=%016h, required none", rspId, rspError, rspData);
            end else begin
               er = exp_rsp.pop_front();
               if ({rspId, rspError, rspData} !== {er.id, er.err, er.data}) begin
                  fails++;
                  $display("FAIL rsp: got id=%0d err=%0d data=%016h, expected id=%0d err=%0d data=%016h",
                           rspId, rspError, rspData, er.id, er.err, er.data);
               end
            end
         end
      end
   end

   task automatic expect_txn(input logic id, input logic [7:0] cmd, input logic [63:0] rdata,
                             input logic err, input int n_strobes);
      exp_rsp_t e;
      if (n_strobes > 0) exp_cmd.push_back(cmd);
      if (n_strobes > 1) exp_cmd.push_back(CMD_ACK);
      e.id = id; e.err = err; e.data = rdata;
      exp_rsp.push_back(e);
   endtask

   task automatic start_req(input logic id, input logic [7:0] cmd, input logic [63:0] data);
      if (id) begin
         req1Valid = 1'b1; req1Cmd = cmd; req1Data = data;
      end else begin
         req0Valid = 1'b1; req0Cmd = cmd; req0Data = data;
      end
   endtask

   // Waits for the ready pulse of one requester and withdraws its request
   task automatic wait_ready(input logic id);
      logic seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (id ? req1Ready : req0Ready) begin
            seen = 1'b1;
            if (id) req1Valid = 1'b0; else req0Valid = 1'b0;
         end
      end
      checks++;
      if (!seen) begin
         fails++;
         $display("FAIL ready_timeout: requester %0d got no ready within 50 cycles, required a grant", id);
         req0Valid = 1'b0; req1Valid = 1'b0;
      end
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      while ((exp_rsp.size() != 0 || exp_cmd.size() != 0) && c < budget) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (exp_rsp.size() != 0 || exp_cmd.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d responses and %0d strobes outstanding, required 0",
                  exp_rsp.size(), exp_cmd.size());
         exp_rsp.delete(); exp_cmd.delete();
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++;
      if ({req0Ready, req1Ready, rspValid, rspId, rspError, commandStrobe} !== 6'b0 ||
          command !== 8'h00 || rspData !== 64'h0 || regIn !== 64'h0) begin
         fails++;
         $display("FAIL %s: rdy=%b%b rspV=%b id=%b err=%b stb=%b cmd=%02h rspData=%016h regIn=%016h, required all zero",
                  tag, req1Ready, req0Ready, rspValid, rspId, rspError, commandStrobe, command, rspData, regIn);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_state");
      reset = 1'b0;
      @(negedge clk);
      check_outputs_zero("post_reset_idle");
   endtask

   task automatic test_basic;
      ack_rise_dly = 3; ack_fall_dly = 1;
      cap_value  = 64'hDEAD_BEEF_0000_1111;
      strobe_cnt = 0;
      expect_txn(1'b0, CMD_BUFFER_CONFIGURE, cap_value, 1'b0, 2);
      @(negedge clk);
      start_req(1'b0, 8'h04, 64'h00000014_00000070);
      wait_ready(1'b0);
      checks++;
      if (regIn !== 64'h0000001400000070) begin
         fails++;
         $display("FAIL basic_regin: got %016h, expected 0000001400000070", regIn);
      end
      wait_drain(100);
      repeat (2) @(negedge clk);
      checks++;
      if (strobe_cnt !== 2) begin
         fails++;
         $display("FAIL basic_strobe_count: got %0d, expected 2", strobe_cnt);
      end
      checks++;
      if (regIn !== 64'h0000001400000070) begin
         fails++;
         $display("FAIL basic_regin_hold: got %016h, expected 0000001400000070", regIn);
      end
      tb_last = 1'b0;
   endtask

   task automatic test_illegal;
      logic       ids[2]  = '{1'b1, 1'b0};
      logic [7:0] cmds[2] = '{CMD_ACK, CMD_NOP};
      for (int i = 0; i < 2; i++) begin
         int lat = 0;
         expect_txn(ids[i], cmds[i], 64'h0, 1'b1, 0);
         @(negedge clk);
         start_req(ids[i], cmds[i], 64'h1234_0000_0000_0000 + 64'(i));
         wait_ready(ids[i]);
         while (!rspValid && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         checks++;
         if (lat > 2) begin
            fails++;
            $display("FAIL illegal_latency: cmd %02h rspValid after %0d cycles, required <= 2", cmds[i], lat);
         end
         wait_drain(20);
         tb_last = ids[i];
      end
   endtask

   task automatic test_round_robin(input int pairs);
      ack_rise_dly = 1; ack_fall_dly = 1;
      cap_value = 64'h0000_0000_0000_0666;
      for (int p = 0; p < pairs; p++) begin
         logic first = ~tb_last;
         logic second = tb_last;
         logic ord[2] = '{1'b0, 1'b0};
         int   n = 0;
         logic got0 = 1'b0, got1 = 1'b0;
         expect_txn(first, CMD_READ_TRACE_SIZE, cap_value, 1'b0, 2);
         expect_txn(second, CMD_READ_TRACE_SIZE, cap_value, 1'b0, 2);
         @(negedge clk);
         start_req(1'b0, CMD_READ_TRACE_SIZE, 64'hA0 + 64'(p));
         start_req(1'b1, CMD_READ_TRACE_SIZE, 64'hB0 + 64'(p));
         for (int c = 0; c < 300 && !(got0 && got1); c++) begin
            @(negedge clk);
            if (req0Ready && !got0) begin
               checks++;
               if (regIn !== 64'hA0 + 64'(p)) begin
                  fails++;
                  $display("FAIL rr_regin0: got %016h, expected %016h", regIn, 64'hA0 + 64'(p));
               end
               if (n < 2) ord[n] = 1'b0;
               n++; got0 = 1'b1; req0Valid = 1'b0;
            end
            if (req1Ready && !got1) begin
               checks++;
               if (regIn !== 64'hB0 + 64'(p)) begin
                  fails++;
                  $display("FAIL rr_regin1: got %016h, expected %016h", regIn, 64'hB0 + 64'(p));
               end
               if (n < 2) ord[n] = 1'b1;
               n++; got1 = 1'b1; req1Valid = 1'b0;
            end
         end
         checks++;
         if (n !== 2 || ord[0] !== first || ord[1] !== second) begin
            fails++;
            $display("FAIL rr_order: pair %0d got %0d grants order %0d,%0d, expected order %0d,%0d",
                     p, n, ord[0], ord[1], first, second);
            req0Valid = 1'b0; req1Valid = 1'b0;
         end
         wait_drain(100);
         tb_last = second;
      end
   endtask

   task automatic test_capture;
      ack_rise_dly = 0; ack_fall_dly = 1;
      cap_value = 64'h00000000_0000002A;
      expect_txn(1'b1, CMD_READ_TRIGGER_SAMPLE, 64'h2A, 1'b0, 2);
      @(negedge clk);
      start_req(1'b1, CMD_READ_TRIGGER_SAMPLE, 64'h77);
      wait_ready(1'b1);
      wait_drain(100);
      tb_last = 1'b1;
   endtask

   task automatic test_reset_midflight;
      int c = 0;
      ack_rise_dly = 1; ack_hold = 1'b1;
      cap_value = 64'h5555_AAAA_5555_AAAA;
      exp_cmd.push_back(CMD_READ_TRACE_DATA);
      exp_cmd.push_back(CMD_ACK);
      @(negedge clk);
      start_req(1'b0, CMD_READ_TRACE_DATA, 64'hFEED);
      wait_ready(1'b0);
      while (exp_cmd.size() != 0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (exp_cmd.size() != 0) begin
         fails++;
         $display("FAIL midflight_strobes: %0d strobes missing, required 0", exp_cmd.size());
         exp_cmd.delete();
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("midflight_reset");
      reset = 1'b0;
      ack_hold = 1'b0;
      tb_last = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rspValid !== 1'b0 || exp_rsp.size() != 0) begin
         fails++;
         $display("FAIL midflight_no_rsp: rspValid=%b queued=%0d, required 0", rspValid, exp_rsp.size());
      end
      test_round_robin(1);
   endtask

`ifdef LOGCAP_SEQ_TIMEOUT_EN
   task automatic test_timeout;
      int lat = 0;
      ack_never = 1'b1;
      expect_txn(1'b0, CMD_START, 64'h0, 1'b1, 1);
      @(negedge clk);
      start_req(1'b0, CMD_START, 64'h99);
      wait_ready(1'b0);
      while (!rspValid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== int'(TB_TMO) + 1) begin
         fails++;
         $display("FAIL timeout_latency: rspValid %0d cycles after strobe, expected %0d", lat, TB_TMO + 1);
      end
      wait_drain(20);
      ack_never = 1'b0;
      ack_rise_dly = 1; ack_fall_dly = 1;
      cap_value = 64'h0BAD_F00D;
      expect_txn(1'b1, CMD_ABORT, cap_value, 1'b0, 2);
      @(negedge clk);
      start_req(1'b1, CMD_ABORT, 64'h1);
      wait_ready(1'b1);
      wait_drain(100);
      tb_last = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_illegal();
      test_round_robin(2);
      test_capture();
      test_reset_midflight();
`ifdef LOGCAP_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (exp_rsp.size() != 0 || exp_cmd.size() != 0) begin
         fails++;
         $display("FAIL final_queues: %0d responses, %0d strobes outstanding, required 0",
                  exp_rsp.size(), exp_cmd.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500000, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/logcap_cmd_sequencer.md
LOGCAP_CMD_SEQUENCER -- requirements
Module: logcap_cmd_sequencer

Interface
REQ-001 Parameter ACK_TIMEOUT_CLKS, default 1024: clocks allowed in WAIT_ACK or WAIT_RELEASE before the transaction is aborted.
REQ-002 Port clk, input, 1: single clock; every flop is rising-edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Ports req0Valid, req1Valid, input, 1 each: requester 0 and requester 1 each have a command pending.
REQ-005 Ports req0Cmd, req1Cmd, input, 8 each: function code for each requester.
REQ-006 Ports req0Data, req1Data, input, 64 each: register payload {regIn7..regIn0} for each requester.
REQ-007 Ports req0Ready, req1Ready, output, 1 each: request accepted this cycle.
REQ-008 Port rspValid, output, 1: single-cycle response pulse.
REQ-009 Port rspId, output, 1: requester that owns the response.
REQ-010 Port rspData, output, 64: captured {regOut7..regOut0}.
REQ-011 Port rspError, output, 1: transaction timed out, or the command was illegal.
REQ-012 Port command, output, 8: function code sent to the capture core.
REQ-013 Port commandStrobe, output, 1: one-cycle strobe that qualifies command.
REQ-014 Port regIn, output, 64: packed regIn7..regIn0.
REQ-015 Port regOut, input, 64: packed regOut7..regOut0.
REQ-016 Port status, input, 8: bit0 idle, bit3 ack.

Function
REQ-017 States: IDLE, ISSUE, WAIT_ACK, CAPTURE, SEND_ACK, WAIT_RELEASE, RESPOND.
REQ-018 IDLE with any reqNValid: grant one requester, pulse its reqNReady for one cycle, latch its Cmd and Data, set regIn to Data, then go to ISSUE.
REQ-019 Arbitration is round-robin: when both requests are valid, grant the requester not granted last; after reset requester 0 wins.
REQ-020 ISSUE: command = latched code and commandStrobe = 1 for exactly one cycle, then go to WAIT_ACK.
REQ-021 WAIT_ACK: when status[3] = 1, go to CAPTURE.
REQ-022 CAPTURE: latch regOut into rspData in one cycle, then go to SEND_ACK.
REQ-023 SEND_ACK: command = 0x08 (CMD_ACK) and commandStrobe = 1 for exactly one cycle, then go to WAIT_RELEASE.
REQ-024 WAIT_RELEASE: when status[3] = 0, go to RESPOND.
REQ-025 RESPOND: rspValid = 1 for one cycle with rspId and rspError = 0, then go to IDLE.
REQ-026 Minimum latency from grant to rspValid is 6 cycles, reached when ack rises the cycle after the strobe and falls the cycle after the CMD_ACK strobe.
REQ-027 A granted command of 0x08 (CMD_ACK) or 0x00 (CMD_NOP) is illegal: go directly to RESPOND with rspError = 1 and no strobe.
REQ-028 regIn holds its value from grant until the next grant.
REQ-029 command returns to 0x00 whenever commandStrobe = 0.
REQ-030 No new grant is made while the state is not IDLE; reqNReady = 0 outside IDLE.
REQ-031 A request that arrives while busy stays pending; nothing is dropped, and reqNValid must remain held until reqNReady.
REQ-032 A status[3] that is already high on entry to WAIT_ACK is accepted immediately.
REQ-033 status[0] is ignored by this block.

Reset
REQ-034 When reset = 1: state = IDLE, commandStrobe = 0, command = 0x00, regIn = 0, rspValid = 0, rspId = 0, rspData = 0, rspError = 0, reqNReady = 0, timeout counter = 0, last-grant = 1.
REQ-035 A reset asserted mid-transaction aborts that transaction with no response, and the outputs meet REQ-034 at the next edge.

Configuration
REQ-036 The macro LOGCAP_SEQ_TIMEOUT_EN compiles in a timeout counter.
REQ-037 With LOGCAP_SEQ_TIMEOUT_EN defined:
- the counter clears on entry to WAIT_ACK and to WAIT_RELEASE;
- after ACK_TIMEOUT_CLKS cycles in either state, go to RESPOND with rspError = 1;
- rspData holds the last CAPTURE value, or 0 if no capture occurred.
REQ-038 Without LOGCAP_SEQ_TIMEOUT_EN: WAIT_ACK and WAIT_RELEASE wait indefinitely, and rspError asserts only for illegal commands.

Structure
REQ-039 Package logcap_pkg holds:
- function codes 0x00-0x09 (NOP, START, ABORT, TRIGGER_CONFIGURE, BUFFER_CONFIGURE, READ_TRACE_DATA, READ_TRACE_SIZE, READ_TRIGGER_SAMPLE, ACK, RESET);
- status bit indices IDLE_BIT = 0 and ACK_BIT = 3;
- the state enumeration.
REQ-040 Sub-module logcap_rr_arbiter: two-requester round-robin grant logic with a last-grant register.

Verification
REQ-041 req0 with 0x04 and Data 0x00000014_00000070; ack rises 3 cycles after the strobe and falls 1 cycle after the CMD_ACK strobe -> exactly two strobes (0x04, then 0x08), regIn = 0x0000001400000070, rspValid with rspId 0 and rspError 0.
REQ-042 req0 and req1 both assert 0x06 in the same cycle, for two transactions -> grants go to 0 then 1; a second simultaneous pair goes to 0 then 1 again.
REQ-043 0x07 with regOut = 0x00000000_0000002A when ack rises -> rspData = 0x2A.
REQ-044 req1 with 0x08 -> no commandStrobe, rspValid with rspError 1 within 2 cycles.
REQ-045 LOGCAP_SEQ_TIMEOUT_EN defined, ACK_TIMEOUT_CLKS = 16, ack never rises -> rspError 1 at cycle 16 of WAIT_ACK, then a new grant is accepted.
REQ-046 Reset asserted in WAIT_RELEASE -> no rspValid, all outputs zero at the next edge, and the next request is granted to requester 0.
